// File: rtl/nmr_signal_generator.sv
// -----------------------------------------------------------------------------
// nmr_signal_generator
//
// Multi-sample DDS for the NMR spectrometer datapath.  Every clock it emits one
// frame of eight 14-bit TX samples (1.6 GS/s DAC) and four 16-bit I/Q LO pairs
// (800 MS/s mixer), all derived from one phase-continuous base accumulator.
//
// Ports
//   clk              system clock (200 MHz), rising edge
//   rst              synchronous active-high reset, priority over enable_gen
//   enable_gen       run; low idles the block and clears the accumulator
//   frq_out          output frequency in Hz
//   TX_phase_data    three 5-bit TX phase slots (10 degree units)
//   RX_phase_data    LO phase (10 degree units)
//   TX_active_phase  TX slot select; 3 blanks the TX output
//   signal_out       8 x signed 14-bit TX samples, sample 0 in the LSBs
//   LO_I / LO_Q      4 x signed 16-bit cosine / sine samples
//   RF_signal_valid  frame on the outputs is valid
//
// Pipeline: inputs/increments -> accumulator/sample phases -> ROM read ->
// output registers (first frame appears after the 4th enabled edge).
// -----------------------------------------------------------------------------
module nmr_signal_generator (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable_gen,
   input  logic [31:0]  frq_out,
   input  logic [14:0]  TX_phase_data,
   input  logic [4:0]   RX_phase_data,
   input  logic [1:0]   TX_active_phase,
   output logic [111:0] signal_out,
   output logic [63:0]  LO_I,
   output logic [63:0]  LO_Q,
   output logic         RF_signal_valid
);

   localparam int unsigned PH_W   = 32;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned TX_W   = 14;
   localparam int unsigned LO_W   = 16;
   localparam int unsigned N_TX   = 8;
   localparam int unsigned N_LO   = 4;
   localparam int unsigned QTR    = 1024;
   localparam int unsigned PROD_W = 58;

   // frq * 2^32 / 1.6e9 expressed as (frq * FRQ_SCALE) >> 24
   localparam logic [PROD_W-1:0] FRQ_SCALE  = PROD_W'(45035996);
   // One 10 degree phase step, ~2^32/36
   localparam logic [PH_W-1:0]   PHASE_STEP = PH_W'(119304647);
   // Rounds the 32-bit phase to the nearest 12-bit ROM address
   localparam logic [PH_W-1:0]   ROUND_HALF = PH_W'(32'h0008_0000);

   // Quarter-wave entry: round(amp * sin(pi/2 * idx/1024)), idx = 0..1024
   function automatic logic [14:0] quarter_sin(input int unsigned idx, input real amp);
      real ang;
      ang = 3.14159265358979323846 * real'(idx) / 2048.0;
      return 15'($rtoi(amp * $sin(ang) + 0.5));
   endfunction

   // Rounded ROM address of a 32-bit phase
   function automatic logic [ADDR_W-1:0] phase_addr(input logic [PH_W-1:0] th);
      return ADDR_W'((th + ROUND_HALF) >> 20);
   endfunction

   // Quarter-wave index: quadrants 1 and 3 read the table mirrored
   function automatic logic [10:0] rom_index(input logic [ADDR_W-1:0] a);
      return a[10] ? (11'(QTR) - {1'b0, a[9:0]}) : {1'b0, a[9:0]};
   endfunction

   function automatic logic [TX_W-1:0] sign_tx(input logic neg, input logic [12:0] mag);
      return neg ? TX_W'(-{1'b0, mag}) : {1'b0, mag};
   endfunction

   function automatic logic [LO_W-1:0] sign_lo(input logic neg, input logic [14:0] mag);
      return neg ? LO_W'(-{1'b0, mag}) : {1'b0, mag};
   endfunction

   // Sine tables, constant after elaboration
   logic [12:0] rom_tx [QTR+1];
   logic [14:0] rom_lo [QTR+1];

   for (genvar gi = 0; gi <= QTR; gi++) begin : g_rom
      assign rom_tx[gi] = 13'(quarter_sin(gi, 8191.0));
      assign rom_lo[gi] = quarter_sin(gi, 32767.0);
   end

   // Stage 1: registered controls and increments
   logic            en1_q, en1_d;
   logic            blank1_q, blank1_d;
   logic [PH_W-1:0] inc_tx1_q, inc_tx1_d;
   logic [PH_W-1:0] inc_lo1_q, inc_lo1_d;
   logic [PH_W-1:0] off_tx1_q, off_tx1_d;
   logic [PH_W-1:0] off_rx1_q, off_rx1_d;

   // Stage 2: base accumulator and per-sample ROM addresses
   logic                        en2_q, en2_d;
   logic                        blank2_q, blank2_d;
   logic [PH_W-1:0]             acc_q, acc_d;
   logic [N_TX-1:0][ADDR_W-1:0] tx_addr2_q, tx_addr2_d;
   logic [N_LO-1:0][ADDR_W-1:0] lo_addr2_q, lo_addr2_d;

   // Stage 3: signed samples
   logic                      en3_q, en3_d;
   logic                      blank3_q, blank3_d;
   logic [N_TX-1:0][TX_W-1:0] tx_samp3_q, tx_samp3_d;
   logic [N_LO-1:0][LO_W-1:0] lo_i3_q, lo_i3_d;
   logic [N_LO-1:0][LO_W-1:0] lo_q3_q, lo_q3_d;

   // Stage 4: output registers
   logic [111:0] signal_out_q, signal_out_d;
   logic [63:0]  lo_i_q, lo_i_d;
   logic [63:0]  lo_q_q, lo_q_d;
   logic         valid_q, valid_d;

   logic [4:0]        tx_sel_c;
   logic [PROD_W-1:0] prod_c;
   logic [ADDR_W-1:0] cos_addr_c;

   // Next-state logic for all pipeline stages
   always_comb begin
      tx_sel_c     = '0;
      prod_c       = '0;
      cos_addr_c   = '0;
      en1_d        = enable_gen;
      blank1_d     = 1'b0;
      inc_tx1_d    = '0;
      inc_lo1_d    = '0;
      off_tx1_d    = '0;
      off_rx1_d    = '0;
      en2_d        = en1_q;
      blank2_d     = blank1_q;
      acc_d        = '0;
      tx_addr2_d   = '0;
      lo_addr2_d   = '0;
      en3_d        = en2_q;
      blank3_d     = blank2_q;
      tx_samp3_d   = '0;
      lo_i3_d      = '0;
      lo_q3_d      = '0;
      signal_out_d = '0;
      lo_i_d       = '0;
      lo_q_d       = '0;
      valid_d      = en3_q;

      // Stage 1
      case (TX_active_phase)
         2'd0:    tx_sel_c = TX_phase_data[4:0];
         2'd1:    tx_sel_c = TX_phase_data[9:5];
         2'd2:    tx_sel_c = TX_phase_data[14:10];
         default: blank1_d = 1'b1;
      endcase
      prod_c    = PROD_W'(frq_out) * FRQ_SCALE;
      inc_tx1_d = PH_W'(prod_c >> 24);
      inc_lo1_d = inc_tx1_d << 1;
      off_tx1_d = PH_W'(tx_sel_c) * PHASE_STEP;
      off_rx1_d = PH_W'(RX_phase_data) * PHASE_STEP;

      // Stage 2: the frame uses acc_q; acc_q then advances by 8 TX samples.
      // Idle cycles clear it so the next run starts from phase zero.
      acc_d = en1_q ? (acc_q + (inc_tx1_q << 3)) : '0;
      for (int k = 0; k < N_TX; k++) begin
         tx_addr2_d[k] = phase_addr(acc_q + PH_W'(k) * inc_tx1_q + off_tx1_q);
      end
      for (int k = 0; k < N_LO; k++) begin
         lo_addr2_d[k] = phase_addr(acc_q + PH_W'(k) * inc_lo1_q + off_rx1_q);
      end

      // Stage 3: quarter-wave lookups; cosine is sine a quarter turn ahead
      for (int k = 0; k < N_TX; k++) begin
         tx_samp3_d[k] = sign_tx(tx_addr2_q[k][11], rom_tx[rom_index(tx_addr2_q[k])]);
      end
      for (int k = 0; k < N_LO; k++) begin
         cos_addr_c  = lo_addr2_q[k] + ADDR_W'(QTR);
         lo_q3_d[k]  = sign_lo(lo_addr2_q[k][11], rom_lo[rom_index(lo_addr2_q[k])]);
         lo_i3_d[k]  = sign_lo(cos_addr_c[11], rom_lo[rom_index(cos_addr_c)]);
      end

      // Stage 4: outputs are zero whenever the frame is not valid
      signal_out_d = (en3_q && !blank3_q) ? tx_samp3_q : '0;
      lo_i_d       = en3_q ? lo_i3_q : '0;
      lo_q_d       = en3_q ? lo_q3_q : '0;
   end

   // Pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         en1_q        <= 1'b0;
         blank1_q     <= 1'b0;
         inc_tx1_q    <= '0;
         inc_lo1_q    <= '0;
         off_tx1_q    <= '0;
         off_rx1_q    <= '0;
         en2_q        <= 1'b0;
         blank2_q     <= 1'b0;
         acc_q        <= '0;
         tx_addr2_q   <= '0;
         lo_addr2_q   <= '0;
         en3_q        <= 1'b0;
         blank3_q     <= 1'b0;
         tx_samp3_q   <= '0;
         lo_i3_q      <= '0;
         lo_q3_q      <= '0;
         signal_out_q <= '0;
         lo_i_q       <= '0;
         lo_q_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         en1_q        <= en1_d;
         blank1_q     <= blank1_d;
         inc_tx1_q    <= inc_tx1_d;
         inc_lo1_q    <= inc_lo1_d;
         off_tx1_q    <= off_tx1_d;
         off_rx1_q    <= off_rx1_d;
         en2_q        <= en2_d;
         blank2_q     <= blank2_d;
         acc_q        <= acc_d;
         tx_addr2_q   <= tx_addr2_d;
         lo_addr2_q   <= lo_addr2_d;
         en3_q        <= en3_d;
         blank3_q     <= blank3_d;
         tx_samp3_q   <= tx_samp3_d;
         lo_i3_q      <= lo_i3_d;
         lo_q3_q      <= lo_q3_d;
         signal_out_q <= signal_out_d;
         lo_i_q       <= lo_i_d;
         lo_q_q       <= lo_q_d;
         valid_q      <= valid_d;
      end
   end

   assign signal_out      = signal_out_q;
   assign LO_I            = lo_i_q;
   assign LO_Q            = lo_q_q;
   assign RF_signal_valid = valid_q;

endmodule

// File: tb/tb_nmr_signal_generator.sv
// -----------------------------------------------------------------------------
// tb_nmr_signal_generator
//
// Directed scenarios plus randomized traffic.  A frame-level model evaluates
// each edge's inputs with real-valued trig and a four-deep latency queue; a
// negedge process compares every output against it, and a few hand-computed
// literals pin the model itself.
// -----------------------------------------------------------------------------
module tb_nmr_signal_generator;

   localparam real PI = 3.14159265358979323846;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable_gen;
   logic [31:0]  frq_out;
   logic [14:0]  TX_phase_data;
   logic [4:0]   RX_phase_data;
   logic [1:0]   TX_active_phase;
   logic [111:0] signal_out;
   logic [63:0]  LO_I;
   logic [63:0]  LO_Q;
   logic         RF_signal_valid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         valid;
      logic [111:0] tx;
      logic [63:0]  li;
      logic [63:0]  lq;
   } frame_t;

   frame_t      pipe [4];
   logic [31:0] model_b = '0;

   nmr_signal_generator dut (
      .clk             (clk),
      .rst             (rst),
      .enable_gen      (enable_gen),
      .frq_out         (frq_out),
      .TX_phase_data   (TX_phase_data),
      .RX_phase_data   (RX_phase_data),
      .TX_active_phase (TX_active_phase),
      .signal_out      (signal_out),
      .LO_I            (LO_I),
      .LO_Q            (LO_Q),
      .RF_signal_valid (RF_signal_valid)
   );

   always #5 clk = ~clk;

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic int ampl(input real amp, input logic [11:0] a, input bit use_cos);
      real ang;
      ang = 2.0 * PI * real'(a) / 4096.0;
      return rnd(amp * (use_cos ? $cos(ang) : $sin(ang)));
   endfunction

   task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Frame model: what the inputs seen at this edge must produce 3 edges later
   always @(posedge clk) begin : model
      frame_t      f;
      logic [31:0] inc, inc_lo, off_tx, off_rx, th;
      logic [14:0] slots;
      logic [11:0] a;
      f.valid = 1'b0;
      f.tx    = '0;
      f.li    = '0;
      f.lq    = '0;
      if (!rst && enable_gen) begin
         inc    = 32'((64'(frq_out) * 64'd45035996) >> 24);
         inc_lo = inc * 32'd2;
         slots  = TX_phase_data >> (5 * int'(TX_active_phase));
         off_tx = 32'(slots[4:0]) * 32'd119304647;
         off_rx = 32'(RX_phase_data) * 32'd119304647;
         f.valid = 1'b1;
         for (int k = 0; k < 8; k++) begin
            th = model_b + 32'(k) * inc + off_tx;
            a  = 12'((th + 32'd524288) >> 20);
            if (TX_active_phase != 2'd3) f.tx[14*k +: 14] = 14'(ampl(8191.0, a, 1'b0));
         end
         for (int k = 0; k < 4; k++) begin
            th = model_b + 32'(k) * inc_lo + off_rx;
            a  = 12'((th + 32'd524288) >> 20);
            f.li[16*k +: 16] = 16'(ampl(32767.0, a, 1'b1));
            f.lq[16*k +: 16] = 16'(ampl(32767.0, a, 1'b0));
         end
         model_b = model_b + 32'd8 * inc;
      end else begin
         model_b = '0;
      end
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = f;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pipe[i].valid = 1'b0;
            pipe[i].tx    = '0;
            pipe[i].li    = '0;
            pipe[i].lq    = '0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      check("valid",      112'(RF_signal_valid), 112'(pipe[3].valid));
      check("signal_out", signal_out,            pipe[3].tx);
      check("LO_I",       112'(LO_I),            112'(pipe[3].li));
      check("LO_Q",       112'(LO_Q),            112'(pipe[3].lq));
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [31:0] f, input logic [14:0] txp, input logic [4:0] rxp,
                      input logic [1:0] slot);
      frq_out         = f;
      TX_phase_data   = txp;
      RX_phase_data   = rxp;
      TX_active_phase = slot;
      enable_gen      = 1'b1;
   endtask

   int r;

   initial begin
      rst             = 1'b1;
      enable_gen      = 1'b0;
      frq_out         = '0;
      TX_phase_data   = '0;
      RX_phase_data   = '0;
      TX_active_phase = '0;
      step(3);
      check("reset valid",  112'(RF_signal_valid), 112'(0));
      check("reset tx",     signal_out, 112'(0));
      check("reset lo_i",   112'(LO_I), 112'(0));
      rst = 1'b0;

      // Phase 0 start at 10 MHz
      run(32'd10_000_000, 15'd0, 5'd0, 2'd0);
      step(3);
      check("valid before E3", 112'(RF_signal_valid), 112'(0));
      step(1);
      check("valid at E3",     112'(RF_signal_valid), 112'(1));
      check("frame0 tx s0",    112'(signal_out[13:0]), 112'(14'd0));
      check("frame0 lo_i s0",  112'(LO_I[15:0]), 112'(16'd32767));
      check("frame0 lo_q s0",  112'(LO_Q[15:0]), 112'(16'd0));
      step(20);
      check("frame20 tx s0",   112'(signal_out[13:0]), 112'(14'd0));
      check("frame20 lo_i s0", 112'(LO_I[15:0]), 112'(16'd32767));

      // TX phase cycling: slot 1 = 90 degrees
      enable_gen = 1'b0;
      step(5);
      run(32'd10_000_000, {5'd0, 5'd9, 5'd0}, 5'd0, 2'd0);
      step(20);
      TX_active_phase = 2'd1;
      step(4);
      check("slot1 frame20 tx s0", 112'(signal_out[13:0]), 112'(14'd8191));
      step(16);
      TX_active_phase = 2'd2;
      step(20);
      TX_active_phase = 2'd0;
      step(6);

      // Phase sweep: 180 then 270 degrees
      enable_gen = 1'b0;
      step(5);
      run(32'd10_000_000, {5'd0, 5'd18, 5'd0}, 5'd0, 2'd1);
      step(4);
      check("180deg tx s0", 112'(signal_out[13:0]), 112'(14'd0));
      check("180deg valid", 112'(RF_signal_valid), 112'(1));
      enable_gen = 1'b0;
      step(5);
      run(32'd10_000_000, {5'd0, 5'd27, 5'd0}, 5'd0, 2'd1);
      step(4);
      check("270deg tx s0", 112'(signal_out[13:0]), 112'(14'h2001));

      // RX phase 90 degrees
      enable_gen = 1'b0;
      step(5);
      run(32'd10_000_000, 15'd0, 5'd9, 2'd0);
      step(4);
      check("rx90 lo_i s0", 112'(LO_I[15:0]), 112'(16'd0));
      check("rx90 lo_q s0", 112'(LO_Q[15:0]), 112'(16'd32767));
      check("rx90 tx s0",   112'(signal_out[13:0]), 112'(14'd0));

      // Blank, then disable and re-enable
      TX_active_phase = 2'd3;
      step(4);
      check("blank tx",    signal_out, 112'(0));
      check("blank valid", 112'(RF_signal_valid), 112'(1));
      enable_gen = 1'b0;
      step(3);
      check("drain valid", 112'(RF_signal_valid), 112'(1));
      step(1);
      check("idle valid",  112'(RF_signal_valid), 112'(0));
      check("idle lo_q",   112'(LO_Q), 112'(0));
      run(32'd10_000_000, 15'd0, 5'd9, 2'd0);
      step(4);
      check("reenable lo_q s0", 112'(LO_Q[15:0]), 112'(16'd32767));

      // Reset mid-run
      step(10);
      rst = 1'b1;
      step(1);
      check("mid rst valid", 112'(RF_signal_valid), 112'(0));
      check("mid rst tx",    signal_out, 112'(0));
      check("mid rst lo_i",  112'(LO_I), 112'(0));
      rst = 1'b0;

      // Nyquist: every TX sample lands on a zero crossing at first
      enable_gen = 1'b0;
      step(2);
      run(32'd800_000_000, 15'd0, 5'd0, 2'd0);
      step(4);
      check("nyquist tx",      signal_out, 112'(0));
      check("nyquist lo_i s0", 112'(LO_I[15:0]), 112'(16'd32767));
      step(300);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r   = int'($urandom_range(0, 99));
         rst = (r < 2);
         if (r >= 2 && r < 5) enable_gen = 1'b0;
         if (!enable_gen && r >= 40) enable_gen = 1'b1;
         if (r >= 5 && r < 12) TX_active_phase = 2'($urandom_range(0, 3));
         if (r >= 12 && r < 14) frq_out = $urandom_range(0, 800_000_000);
         if (r == 14) frq_out = $urandom;
         if (r >= 15 && r < 17) TX_phase_data = 15'($urandom);
         if (r == 17) RX_phase_data = 5'($urandom);
         step(1);
      end

      rst = 1'b1;
      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
